// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding bus request and a one-entry output buffer.
// Redirects flush the buffer and steer fetch. A response to a flushed request is dropped.
module fetch_unit #(
  parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ibus_req_valid,
  output logic [63:0] ibus_req_addr,
  input  logic        ibus_addr_ok,
  input  logic        ibus_data_ok,
  input  logic [31:0] ibus_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_exc
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDiscard} state_e;

  state_e      state_q, state_d;
  logic [63:0] fetch_pc_q, fetch_pc_d;
  logic [63:0] req_addr_q, req_addr_d;
  logic        halt_q, halt_d;
  logic        kill_q, kill_d;
  logic        buf_valid_q, buf_valid_d;
  logic [63:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic        buf_exc_q, buf_exc_d;

  logic        consume, buf_free, load, load_exc;
  logic [63:0] load_pc;
  logic [31:0] load_instr;

  assign consume  = buf_valid_q && out_ready;
  assign buf_free = !buf_valid_q || consume;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    halt_d     = halt_q;
    kill_d     = 1'b0;
    load       = 1'b0;
    load_pc    = fetch_pc_q;
    load_instr = ibus_data;
    load_exc   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!redirect_valid && !halt_q && buf_free) begin
          if (fetch_pc_q[1:0] == 2'b00) begin
            state_d    = StReq;
            req_addr_d = fetch_pc_q;
          end else begin
            // Misaligned target: present a nop flagged as an exception, then stall.
            load       = 1'b1;
            load_instr = 32'h0000_0013;
            load_exc   = 1'b1;
            halt_d     = 1'b1;
          end
        end
      end
      StReq: begin
        if (ibus_addr_ok) begin
          if (ibus_data_ok) begin
            state_d = StIdle;
            if (!kill_q && !redirect_valid) begin
              load       = 1'b1;
              load_pc    = req_addr_q;
              fetch_pc_d = fetch_pc_q + 64'd4;
            end
          end else begin
            state_d = (kill_q || redirect_valid) ? StDiscard : StWait;
          end
        end else begin
          // Address must stay on the bus; remember that the response is stale.
          kill_d = kill_q || redirect_valid;
        end
      end
      StWait: begin
        if (ibus_data_ok) begin
          state_d = StIdle;
          if (!redirect_valid) begin
            load       = 1'b1;
            fetch_pc_d = fetch_pc_q + 64'd4;
          end
        end else if (redirect_valid) begin
          state_d = StDiscard;
        end
      end
      StDiscard: begin
        if (ibus_data_ok) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      halt_d     = 1'b0;
    end
  end

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    buf_exc_d   = buf_exc_q;
    if (redirect_valid) begin
      buf_valid_d = 1'b0;
    end else if (load) begin
      buf_valid_d = 1'b1;
      buf_pc_d    = load_pc;
      buf_instr_d = load_instr;
      buf_exc_d   = load_exc;
    end else if (consume) begin
      buf_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      fetch_pc_q  <= PC_RESET;
      req_addr_q  <= PC_RESET;
      halt_q      <= 1'b0;
      kill_q      <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_pc_q    <= 64'd0;
      buf_instr_q <= 32'd0;
      buf_exc_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_addr_q  <= req_addr_d;
      halt_q      <= halt_d;
      kill_q      <= kill_d;
      buf_valid_q <= buf_valid_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
      buf_exc_q   <= buf_exc_d;
    end
  end

  assign ibus_req_valid = (state_q == StReq);
  assign ibus_req_addr  = req_addr_q;
  assign out_valid      = buf_valid_q;
  assign out_pc         = buf_pc_q;
  assign out_instr      = buf_instr_q;
  assign out_exc        = buf_exc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming fetch, stall, redirects, misalignment, reset abort.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ibus_req_valid;
  logic [63:0] ibus_req_addr;
  logic        ibus_addr_ok;
  logic        ibus_data_ok;
  logic [31:0] ibus_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_exc;

  int tests = 0;
  int fails = 0;

  fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .ibus_req_valid(ibus_req_valid),
    .ibus_req_addr (ibus_req_addr),
    .ibus_addr_ok  (ibus_addr_ok),
    .ibus_data_ok  (ibus_data_ok),
    .ibus_data     (ibus_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .out_exc       (out_exc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [63:0] pc,
                           input logic [31:0] ins, input logic exc);
    check({tag, ".valid"}, {63'd0, out_valid}, {63'd0, v});
    if (v) begin
      check({tag, ".pc"}, out_pc, pc);
      check({tag, ".instr"}, {32'd0, out_instr}, {32'd0, ins});
      check({tag, ".exc"}, {63'd0, out_exc}, {63'd0, exc});
    end
  endtask

  task automatic check_req(input string tag, input logic v, input logic [63:0] addr);
    check({tag, ".req_valid"}, {63'd0, ibus_req_valid}, {63'd0, v});
    if (v) check({tag, ".req_addr"}, ibus_req_addr, addr);
  endtask

  initial begin
    reset = 1'b0;
    ibus_addr_ok = 1'b0;
    ibus_data_ok = 1'b0;
    ibus_data = 32'd0;
    redirect_valid = 1'b0;
    redirect_pc = 64'd0;
    out_ready = 1'b1;

    tick();
    tick();
    check_req("rst", 1'b0, 64'd0);
    check("rst.valid", {63'd0, out_valid}, 64'd0);
    check("rst.pc", out_pc, 64'd0);
    check("rst.instr", {32'd0, out_instr}, 64'd0);
    check("rst.exc", {63'd0, out_exc}, 64'd0);

    // Release; first request one edge later at the reset PC.
    reset = 1'b1;
    check_req("rel0", 1'b0, 64'd0);
    tick();
    check_req("rel1", 1'b1, 64'h8000_0000);

    // Streaming fetch: addr_ok then data_ok, then coincident, then split again.
    ibus_addr_ok = 1'b1;
    tick();
    check_req("s0.wait", 1'b0, 64'd0);
    ibus_addr_ok = 1'b0; ibus_data_ok = 1'b1; ibus_data = 32'h1111_1111;
    tick();
    check_out("s0", 1'b1, 64'h8000_0000, 32'h1111_1111, 1'b0);
    ibus_data_ok = 1'b0;
    tick();
    check_out("s1.empty", 1'b0, 64'd0, 32'd0, 1'b0);
    check_req("s1", 1'b1, 64'h8000_0004);
    ibus_addr_ok = 1'b1; ibus_data_ok = 1'b1; ibus_data = 32'h2222_2222;
    tick();
    check_out("s1", 1'b1, 64'h8000_0004, 32'h2222_2222, 1'b0);
    ibus_addr_ok = 1'b0; ibus_data_ok = 1'b0;
    tick();
    check_req("s2", 1'b1, 64'h8000_0008);
    ibus_addr_ok = 1'b1;
    tick();
    ibus_addr_ok = 1'b0; ibus_data_ok = 1'b1; ibus_data = 32'h3333_3333;
    tick();
    check_out("s2", 1'b1, 64'h8000_0008, 32'h3333_3333, 1'b0);
    ibus_data_ok = 1'b0;

    // Backpressure: entry held, no request while full.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out("stall", 1'b1, 64'h8000_0008, 32'h3333_3333, 1'b0);
      check_req("stall", 1'b0, 64'd0);
    end
    out_ready = 1'b1;
    tick();
    check_out("unstall", 1'b0, 64'd0, 32'd0, 1'b0);
    check_req("unstall", 1'b1, 64'h8000_000C);

    // Redirect coinciding with data_ok in WAIT: data dropped, refetch at target.
    ibus_addr_ok = 1'b1;
    tick();
    check_req("rw.wait", 1'b0, 64'd0);
    ibus_addr_ok = 1'b0; ibus_data_ok = 1'b1; ibus_data = 32'hAAAA_AAAA;
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
    tick();
    check_out("rw.drop", 1'b0, 64'd0, 32'd0, 1'b0);
    check_req("rw.idle", 1'b0, 64'd0);
    ibus_data_ok = 1'b0; redirect_valid = 1'b0;
    tick();
    check_req("rw.next", 1'b1, 64'h8000_0100);

    // Redirect to a misaligned target during a completing REQ.
    ibus_addr_ok = 1'b1; ibus_data_ok = 1'b1; ibus_data = 32'hCCCC_CCCC;
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0002;
    tick();
    check_out("mis.drop", 1'b0, 64'd0, 32'd0, 1'b0);
    ibus_addr_ok = 1'b0; ibus_data_ok = 1'b0; redirect_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    check_out("mis", 1'b1, 64'h8000_0002, 32'h0000_0013, 1'b1);
    check_req("mis", 1'b0, 64'd0);
    tick();
    check_out("mis.hold", 1'b1, 64'h8000_0002, 32'h0000_0013, 1'b1);
    out_ready = 1'b1;
    tick();
    check_out("mis.cons", 1'b0, 64'd0, 32'd0, 1'b0);
    check_req("halt0", 1'b0, 64'd0);
    tick();
    check_req("halt1", 1'b0, 64'd0);
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
    tick();
    check_req("unhalt", 1'b0, 64'd0);
    redirect_valid = 1'b0;
    tick();
    check_req("unhalt.req", 1'b1, 64'h8000_0200);

    // Reset pulse while in WAIT, then a stray data_ok after release.
    ibus_addr_ok = 1'b1;
    tick();
    check_req("rw2.wait", 1'b0, 64'd0);
    ibus_addr_ok = 1'b0;
    #1 reset = 1'b0;
    #1;
    check_req("arst", 1'b0, 64'd0);
    check("arst.valid", {63'd0, out_valid}, 64'd0);
    check("arst.pc", out_pc, 64'd0);
    check("arst.instr", {32'd0, out_instr}, 64'd0);
    check("arst.exc", {63'd0, out_exc}, 64'd0);
    tick();
    reset = 1'b1;
    ibus_data_ok = 1'b1; ibus_data = 32'hBBBB_BBBB;
    tick();
    check_out("stray", 1'b0, 64'd0, 32'd0, 1'b0);
    check_req("rel2", 1'b1, 64'h8000_0000);

    // Redirect in first REQ cycle with addr_ok held off: address held, response dropped.
    ibus_data_ok = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 64'h8000_1000;
    tick();
    redirect_valid = 1'b0;
    check_req("hold0", 1'b1, 64'h8000_0000);
    tick();
    check_req("hold1", 1'b1, 64'h8000_0000);
    tick();
    check_req("hold2", 1'b1, 64'h8000_0000);
    ibus_addr_ok = 1'b1;
    tick();
    check_req("disc", 1'b0, 64'd0);
    check_out("disc", 1'b0, 64'd0, 32'd0, 1'b0);
    ibus_addr_ok = 1'b0; ibus_data_ok = 1'b1; ibus_data = 32'hDEAD_BEEF;
    tick();
    check_out("disc.drop", 1'b0, 64'd0, 32'd0, 1'b0);
    ibus_data_ok = 1'b0;
    tick();
    check_out("disc.after", 1'b0, 64'd0, 32'd0, 1'b0);
    check_req("disc.next", 1'b1, 64'h8000_1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
